// File: rtl/lsb_rs_ordered_if.sv
// Dispatch, CDB snoop and issue-side signals of the ordered load/store reservation station.
interface lsb_rs_ordered_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned NUM_CDB = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                        full;
    logic [CNT_W-1:0]            count;

    logic                        disp_valid;
    logic [OP_W-1:0]             disp_op;
    logic [DATA_W-1:0]           disp_imm;
    logic [DATA_W-1:0]           disp_pc;
    logic                        disp_r1_valid;
    logic                        disp_r2_valid;
    logic [DATA_W-1:0]           disp_r1_data;
    logic [DATA_W-1:0]           disp_r2_data;
    logic [TAG_W-1:0]            disp_r1_tag;
    logic [TAG_W-1:0]            disp_r2_tag;
    logic [TAG_W-1:0]            disp_dest_tag;

    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]    cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]   cdb_data;

    logic                        out_valid;
    logic                        out_ready;
    logic [OP_W-1:0]             out_op;
    logic [DATA_W-1:0]           out_r1;
    logic [DATA_W-1:0]           out_r2;
    logic [DATA_W-1:0]           out_imm;
    logic [DATA_W-1:0]           out_pc;
    logic [TAG_W-1:0]            out_dest_tag;

    modport master (
        output disp_valid, disp_op, disp_imm, disp_pc,
               disp_r1_valid, disp_r2_valid, disp_r1_data, disp_r2_data,
               disp_r1_tag, disp_r2_tag, disp_dest_tag,
               cdb_valid, cdb_tag, cdb_data, out_ready,
        input  full, count, out_valid, out_op, out_r1, out_r2, out_imm, out_pc, out_dest_tag
    );

    modport slave (
        input  disp_valid, disp_op, disp_imm, disp_pc,
               disp_r1_valid, disp_r2_valid, disp_r1_data, disp_r2_data,
               disp_r1_tag, disp_r2_tag, disp_dest_tag,
               cdb_valid, cdb_tag, cdb_data, out_ready,
        output full, count, out_valid, out_op, out_r1, out_r2, out_imm, out_pc, out_dest_tag
    );
endinterface

// File: rtl/lsb_rs_ordered.sv
// Age-ordered reservation station: collapsing queue with CDB wakeup/bypass and
// oldest-ready issue through a valid/ready output register.
module lsb_rs_ordered #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned NUM_CDB = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             rdy,
    input logic             clear,
    lsb_rs_ordered_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } opnd_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  dest;
        opnd_t             r1;
        opnd_t             r2;
    } entry_t;

    entry_t                    ent     [DEPTH];
    entry_t                    ent_up  [DEPTH];
    entry_t                    ent_nxt [DEPTH];
    entry_t                    new_ent;
    opnd_t                     d1;
    opnd_t                     d2;
    logic [CNT_W-1:0]          count_q;
    logic [DEPTH-1:0]          ready;
    logic [IDX_W-1:0]          sel;
    logic [IDX_W-1:0]          wr_idx;
    logic                      any_ready;
    logic                      issue_ok;
    logic                      do_issue;
    logic                      accept;
    logic                      full_c;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;

    logic                      out_valid_q;
    logic [OP_W-1:0]           out_op_q;
    logic [DATA_W-1:0]         out_r1_q;
    logic [DATA_W-1:0]         out_r2_q;
    logic [DATA_W-1:0]         out_imm_q;
    logic [DATA_W-1:0]         out_pc_q;
    logic [TAG_W-1:0]          out_dest_q;

    assign cdb_valid = bus.cdb_valid;
    assign cdb_tag   = bus.cdb_tag;
    assign cdb_data  = bus.cdb_data;

    // Capture a pending operand from the CDB; the lowest matching channel wins.
    function automatic opnd_t wake(input opnd_t o);
        opnd_t r;
        r = o;
        if (!o.valid) begin
            for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == o.tag) begin
                    r.valid = 1'b1;
                    r.data  = cdb_data[k*DATA_W +: DATA_W];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        ready     = '0;
        any_ready = 1'b0;
        sel       = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            ready[i] = (i < int'(count_q)) && ent[i].r1.valid && ent[i].r2.valid;
            if (ready[i]) begin
                any_ready = 1'b1;
                sel       = IDX_W'(i);
            end
        end

        full_c   = (count_q == CNT_W'(DEPTH));
        issue_ok = !out_valid_q || bus.out_ready;
        do_issue = issue_ok && any_ready;
        accept   = bus.disp_valid && !full_c;
        wr_idx   = IDX_W'(count_q - CNT_W'(do_issue));

        d1.valid = bus.disp_r1_valid;
        d1.tag   = bus.disp_r1_tag;
        d1.data  = bus.disp_r1_data;
        d2.valid = bus.disp_r2_valid;
        d2.tag   = bus.disp_r2_tag;
        d2.data  = bus.disp_r2_data;
        new_ent.op   = bus.disp_op;
        new_ent.imm  = bus.disp_imm;
        new_ent.pc   = bus.disp_pc;
        new_ent.dest = bus.disp_dest_tag;
        new_ent.r1   = wake(d1);
        new_ent.r2   = wake(d2);

        for (int i = 0; i < int'(DEPTH); i++) ent_up[i] = '0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) ent_up[i] = ent[i+1];

        // Collapse above the issued slot, then apply wakeup to the post-shift contents.
        for (int i = 0; i < int'(DEPTH); i++) begin
            ent_nxt[i]    = (do_issue && i >= int'(sel)) ? ent_up[i] : ent[i];
            ent_nxt[i].r1 = wake(ent_nxt[i].r1);
            ent_nxt[i].r2 = wake(ent_nxt[i].r2);
        end
        if (accept) ent_nxt[wr_idx] = new_ent;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_r1_q    <= '0;
            out_r2_q    <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            out_dest_q  <= '0;
        end else if (rdy) begin
            for (int i = 0; i < int'(DEPTH); i++) ent[i] <= ent_nxt[i];
            count_q <= count_q + CNT_W'(accept) - CNT_W'(do_issue);
            if (issue_ok) begin
                out_valid_q <= any_ready;
                if (any_ready) begin
                    out_op_q   <= ent[sel].op;
                    out_r1_q   <= ent[sel].r1.data;
                    out_r2_q   <= ent[sel].r2.data;
                    out_imm_q  <= ent[sel].imm;
                    out_pc_q   <= ent[sel].pc;
                    out_dest_q <= ent[sel].dest;
                end
            end
        end
    end

    assign bus.full         = full_c;
    assign bus.count        = count_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_op       = out_op_q;
    assign bus.out_r1       = out_r1_q;
    assign bus.out_r2       = out_r2_q;
    assign bus.out_imm      = out_imm_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_dest_tag = out_dest_q;
endmodule

// File: tb/tb_lsb_rs_ordered.sv
// Directed scoreboard bench for lsb_rs_ordered: ordering, wakeup, bypass, backpressure, full, flush, stall.
module tb_lsb_rs_ordered;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned NUM_CDB = 4;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [TAG_W-1:0]  dest;
    } item_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  rdy;
    logic  clear;
    int    n_cmp = 0;
    int    n_err = 0;
    item_t exp_q[$];

    lsb_rs_ordered_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W),
                        .NUM_CDB(NUM_CDB)) bus ();

    lsb_rs_ordered #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W),
                     .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic item_t mk(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                                 input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2);
        item_t it;
        it.op   = op;
        it.imm  = 32'(dest) * 4;
        it.pc   = 32'h4000 + 32'(dest) * 16;
        it.r1   = r1;
        it.r2   = r2;
        it.dest = dest;
        return it;
    endfunction

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = '0;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                        input logic r1v, input logic [DATA_W-1:0] r1, input logic [TAG_W-1:0] r1t,
                        input logic r2v, input logic [DATA_W-1:0] r2, input logic [TAG_W-1:0] r2t);
        bus.disp_valid    = 1'b1;
        bus.disp_op       = op;
        bus.disp_imm      = 32'(dest) * 4;
        bus.disp_pc       = 32'h4000 + 32'(dest) * 16;
        bus.disp_dest_tag = dest;
        bus.disp_r1_valid = r1v;
        bus.disp_r1_data  = r1;
        bus.disp_r1_tag   = r1t;
        bus.disp_r2_valid = r2v;
        bus.disp_r2_data  = r2;
        bus.disp_r2_tag   = r2t;
    endtask

    task automatic cdb(input int k, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        bus.cdb_valid[k]                = 1'b1;
        bus.cdb_tag[k*TAG_W +: TAG_W]   = tag;
        bus.cdb_data[k*DATA_W +: DATA_W] = data;
    endtask

    // Score the handshake that the coming edge completes, then advance one cycle.
    task automatic tick();
        item_t got;
        item_t e;
        if (rdy && !rst && !clear && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_issue: observed dest %0h expected no issue", bus.out_dest_tag);
            end
            if (exp_q.size() != 0) begin
                e        = exp_q.pop_front();
                got.op   = bus.out_op;
                got.imm  = bus.out_imm;
                got.pc   = bus.out_pc;
                got.r1   = bus.out_r1;
                got.r2   = bus.out_r2;
                got.dest = bus.out_dest_tag;
                n_cmp++;
                assert (got === e) else begin
                    n_err++;
                    $error("FAIL issue: observed %h expected %h", got, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        bus.out_ready = 1'b1;
        bus.cdb_tag = '0; bus.cdb_data = '0;
        idle();
        disp(6'd0, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        bus.disp_valid = 1'b0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_r1", 64'(bus.out_r1), 64'd0);

        // Basic: both operands ready at dispatch
        disp(6'd3, 4'd2, 1'b1, 32'h100, 4'd0, 1'b1, 32'h5, 4'd0);
        exp_q.push_back(mk(6'd3, 4'd2, 32'h100, 32'h5));
        tick(); idle();
        chk("basic_not_yet", 64'(bus.out_valid), 64'd0);
        chk("basic_count1", 64'(bus.count), 64'd1);
        tick();
        chk("basic_out_valid", 64'(bus.out_valid), 64'd1);
        chk("basic_out_r1", 64'(bus.out_r1), 64'h100);
        chk("basic_out_dest", 64'(bus.out_dest_tag), 64'd2);
        chk("basic_count0", 64'(bus.count), 64'd0);
        drain("basic_drain");

        // Ordering: older A waits on tag 7, younger B ready issues first
        disp(6'h21, 4'd1, 1'b0, 32'h0, 4'd7, 1'b1, 32'h2, 4'd0);
        tick();
        disp(6'h22, 4'd2, 1'b1, 32'hB1, 4'd0, 1'b1, 32'hB2, 4'd0);
        exp_q.push_back(mk(6'h22, 4'd2, 32'hB1, 32'hB2));
        tick(); idle();
        cdb(2, 4'd7, 32'h44);
        exp_q.push_back(mk(6'h21, 4'd1, 32'h44, 32'h2));
        tick(); idle();
        chk("order_count", 64'(bus.count), 64'd1);
        chk("order_first_dest", 64'(bus.out_dest_tag), 64'd2);
        drain("order_drain");

        // Multi-match: lowest channel wins
        disp(6'h23, 4'd3, 1'b0, 32'h0, 4'd7, 1'b1, 32'h3, 4'd0);
        tick(); idle();
        cdb(0, 4'd7, 32'h11);
        cdb(3, 4'd7, 32'h22);
        exp_q.push_back(mk(6'h23, 4'd3, 32'h11, 32'h3));
        tick(); idle();
        drain("multi_drain");

        // Backpressure: three ready entries, output held
        bus.out_ready = 1'b0;
        for (int i = 4; i < 7; i++) begin
            disp(6'h30, 4'(i), 1'b1, 32'hD0 + 32'(i), 4'd0, 1'b1, 32'(i), 4'd0);
            exp_q.push_back(mk(6'h30, 4'(i), 32'hD0 + 32'(i), 32'(i)));
            tick();
        end
        idle();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_dest", 64'(bus.out_dest_tag), 64'd4);
            chk("bp_r1", 64'(bus.out_r1), 64'hD4);
            chk("bp_count", 64'(bus.count), 64'd2);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_drain_count1", 64'(bus.count), 64'd1);
        chk("bp_drain_dest5", 64'(bus.out_dest_tag), 64'd5);
        drain("bp_drain");

        // Full: eight entries waiting on tag 9, ninth dispatch dropped
        for (int i = 0; i < 8; i++) begin
            disp(6'h10, 4'(i), 1'b1, 32'h100 + 32'(i), 4'd0, 1'b0, 32'h0, 4'd9);
            tick();
        end
        idle();
        chk("full_set", 64'(bus.full), 64'd1);
        chk("full_count", 64'(bus.count), 64'd8);
        disp(6'h11, 4'd15, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        tick(); idle();
        chk("full_drop_count", 64'(bus.count), 64'd8);
        chk("full_drop_no_issue", 64'(bus.out_valid), 64'd0);
        cdb(1, 4'd9, 32'h99);
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(6'h10, 4'(i), 32'h100 + 32'(i), 32'h99));
        tick(); idle();
        chk("full_after_wake", 64'(bus.full), 64'd1);
        tick();
        chk("full_cleared", 64'(bus.full), 64'd0);
        chk("full_count7", 64'(bus.count), 64'd7);
        drain("full_drain");
        chk("full_count0", 64'(bus.count), 64'd0);

        // Bypass on dispatch while an older entry issues the same cycle
        disp(6'h05, 4'd10, 1'b1, 32'hE1, 4'd0, 1'b1, 32'hE2, 4'd0);
        exp_q.push_back(mk(6'h05, 4'd10, 32'hE1, 32'hE2));
        tick();
        disp(6'h06, 4'd11, 1'b1, 32'hF1, 4'd0, 1'b0, 32'h0, 4'd5);
        cdb(1, 4'd5, 32'hABCD);
        exp_q.push_back(mk(6'h06, 4'd11, 32'hF1, 32'hABCD));
        tick(); idle();
        chk("bypass_count", 64'(bus.count), 64'd1);
        chk("bypass_older_dest", 64'(bus.out_dest_tag), 64'd10);
        tick();
        chk("bypass_r2", 64'(bus.out_r2), 64'hABCD);
        drain("bypass_drain");

        // Flush with a held output and four entries
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp(6'h07, 4'(i), 1'b1, 32'h70, 4'd0, 1'b1, 32'h71, 4'd0);
            tick();
        end
        idle();
        chk("flush_pre_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_pre_count", 64'(bus.count), 64'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_count", 64'(bus.count), 64'd0);
        bus.out_ready = 1'b1;

        // Stall: broadcast during rdy=0 must not be captured
        disp(6'h08, 4'd12, 1'b0, 32'h0, 4'd6, 1'b1, 32'h81, 4'd0);
        tick(); idle();
        rdy = 1'b0;
        cdb(0, 4'd6, 32'h66);
        disp(6'h09, 4'd13, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        tick(); tick();
        idle();
        chk("stall_hold_count", 64'(bus.count), 64'd1);
        rdy = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("stall_no_issue", 64'(bus.out_valid), 64'd0);
        chk("stall_count", 64'(bus.count), 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("final_count", 64'(bus.count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lsb_rs_ordered.md
Name: lsb_rs_ordered

Overview:
Parametrised, age-ordered reservation station in front of the load/store buffer. It holds dispatched memory ops until both operands are resolved, snooping NUM_CDB result buses. It issues the oldest ready entry through a valid/ready output register, so downstream backpressure is honoured. Compared with the single-slot-scan RS, it adds configurable depth/width/CDB count, strict oldest-first issue, same-cycle dispatch bypass from the CDB, an occupancy count and output stalling.

Parameters:
DEPTH, 8, number of entries (>=2)
DATA_W, 32, operand/immediate/pc width
TAG_W, 4, ROB tag width
OP_W, 6, opcode width
NUM_CDB, 4, number of broadcast result channels

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when 0 all state holds
clear  in  1  synchronous flush (mispredict), same effect as rst
full  out  1  count==DEPTH (combinational from state)
count  out  $clog2(DEPTH)+1  occupied entries
disp_valid  in  1  dispatch request
disp_op  in  OP_W  opcode
disp_imm  in  DATA_W  immediate
disp_pc  in  DATA_W  instruction pc
disp_r1_valid / disp_r2_valid  in  1  operand already resolved
disp_r1_data / disp_r2_data  in  DATA_W  operand value
disp_r1_tag / disp_r2_tag  in  TAG_W  producer ROB tag
disp_dest_tag  in  TAG_W  this op's ROB tag
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  packed tags, channel k at [k*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*DATA_W  packed data
out_valid  out  1  issued op present
out_ready  in  1  LSB accepts
out_op  out  OP_W
out_r1, out_r2, out_imm, out_pc  out  DATA_W
out_dest_tag  out  TAG_W

Behaviour:
- rst or clear (rst checked first, independent of rdy): all entries invalid, count=0, out_valid=0, all out_* data=0. A flush mid-stall drops the held output.
- rdy=0: no state change. Outputs stay stable. Dispatch, CDB and out_ready are ignored.
- Storage is a collapsing queue. Slots 0..count-1 are valid, and slot 0 is the oldest.
- Wakeup: a valid entry operand with valid=0 captures data from any channel k where cdb_valid[k] and tag match. If several channels match, the lowest k wins. The operand is marked valid at the edge and is issue-eligible the next cycle.
- Ready(i) = slot valid && r1 valid && r2 valid, evaluated on registered state (not on this cycle's CDB).
- Issue allowed when !out_valid || out_ready. It selects the lowest-index ready slot, loads out_* at the edge, sets out_valid=1, and collapses slots above it down by one. Latency: operands become valid at edge t, out_valid is seen after edge t+1.
- If issue is not allowed, out_* and out_valid hold. When out_ready=1 with no ready entry, out_valid clears to 0 and data holds its value (don't-care).
- Dispatch accepted when disp_valid && !full, with full evaluated before this edge's issue. A slot freed by issue in the same cycle is not reused. The new entry is written at slot count (or count-1 if an issue collapses this cycle). Dispatch while full is dropped silently; the dispatcher must check full.
- Dispatch bypass: if disp_rX_valid=0 and a CDB channel matches disp_rX_tag in the same cycle, the entry stores that data with valid=1.
- Wakeup applies to entries that shift during a collapse: the shifted entry carries its captured data.
- count next = count + accept - issue. It never wraps.

Test Plan:
- Reset/basic: after rst, dispatch op=3 r1=0x100 r2=0x5 (both valid) dest=2 imm=8 -> out_valid at 2nd edge after dispatch edge, out_r1=0x100, out_dest_tag=2, count returns 0.
- Ordering: dispatch A(tag1, r1 waits tag 7), then B(tag2, ready), then CDB ch2 tag7 data 0x44 -> B issues first. A issues next with out_r1=0x44. Multi-match: ch0 tag7=0x11 and ch3 tag7=0x22 in the same cycle -> out_r1=0x11.
- Backpressure: out_ready=0 with 3 ready entries -> out_* stable for 5 cycles, count=2. Then out_ready=1 -> entries drain oldest-first, one per cycle.
- Full: fill DEPTH=8 entries waiting on tag 9 -> full=1. A 9th dispatch is dropped. Broadcast tag9 -> 8 issues, count reaches 0, full clears after the first issue.
- Bypass plus simultaneous dispatch/issue: dispatch r2 tag 5 while CDB ch1 broadcasts tag5=0xABCD, and an older entry issues in the same cycle -> count unchanged. The new entry issues next with out_r2=0xABCD.
- Flush/stall: clear with out_valid=1 and 4 entries -> out_valid=0, count=0 next cycle. With rdy=0, a CDB broadcast is not captured and the waiting entry never issues.
